pc_update_unit: RTL and testbench

- Program-counter stage directly downstream of the branch/jump decision logic.
- Consumes the 1-bit FLOW_SELECT decision and the instruction's 8-bit word offset, then registers the next PC: sequential PC+4, or the branch/jump target.
- Holds the PC while instruction/data memory asserts BUSYWAIT.
- Provides a fetch-valid qualifier, a one-cycle redirect pulse and a saturating taken-branch counter for debug.

---
 rtl/pc_update_unit_if.sv | 28 ++
 rtl/pc_update_unit.sv | 95 +++++++++
 tb/tb_pc_update_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pc_update_unit_if.sv
// Bus between the branch/jump decision logic, memory stall source and the PC stage.
interface pc_update_unit_if #(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned OFFSET_WIDTH = 8
);
  localparam int unsigned CNT_WIDTH = 16;

  logic                    FLOW_SELECT;
  logic [OFFSET_WIDTH-1:0] BRANCH_OFFSET;
  logic                    BUSYWAIT;
  logic [PC_WIDTH-1:0]     PC;
  logic [PC_WIDTH-1:0]     PC_PLUS4;
  logic                    INSTR_VALID;
  logic                    REDIRECT;
  logic [CNT_WIDTH-1:0]    TAKEN_COUNT;

  // Upstream side: supplies the flow decision and stall, observes the PC.
  modport master (
    output FLOW_SELECT, BRANCH_OFFSET, BUSYWAIT,
    input  PC, PC_PLUS4, INSTR_VALID, REDIRECT, TAKEN_COUNT
  );

  // PC stage side.
  modport slave (
    input  FLOW_SELECT, BRANCH_OFFSET, BUSYWAIT,
    output PC, PC_PLUS4, INSTR_VALID, REDIRECT, TAKEN_COUNT
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter stage: sequential/branch next-PC select, stall hold,
// one-cycle boot settle, redirect pulse and saturating taken counter.
module pc_update_unit #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter int unsigned          OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input logic               CLK,
  input logic               RESET,
  pc_update_unit_if.slave   bus
);
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic                  redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   offset_ext;
  logic [PC_WIDTH-1:0]   target;

  // Address arithmetic, all modulo 2^PC_WIDTH.
  always_comb begin
    pc_plus4   = pc_q + PC_WIDTH'(4);
    offset_ext = PC_WIDTH'($signed(bus.BRANCH_OFFSET));
    target     = pc_plus4 + (offset_ext << 2);
  end

  // State and datapath registers; reset discards any pending stall.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
      count_q    <= count_d;
    end
  end

  // Next-state and next-PC selection; STALL resumes with the inputs at the release edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = 1'b0;
    count_d    = count_q;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, STALL: begin
        if (bus.BUSYWAIT) begin
          state_d = STALL;
        end else begin
          state_d = RUN;
          if (bus.FLOW_SELECT) begin
            pc_d       = target;
            redirect_d = 1'b1;
            if (count_q != '1) begin
              count_d = count_q + CNT_WIDTH'(1);
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    valid_d = (state_d != BOOT);
  end

  // Output drive.
  always_comb begin
    bus.PC          = pc_q;
    bus.PC_PLUS4    = pc_plus4;
    bus.INSTR_VALID = valid_q;
    bus.REDIRECT    = redirect_q;
    bus.TAKEN_COUNT = count_q;
  end
endmodule

// File: tb/tb_pc_update_unit.sv
// Randomized and directed bench for pc_update_unit against a behavioural PC model.
module tb_pc_update_unit;
  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  // Reference model state.
  logic [31:0] m_pc;
  bit          m_booting;
  bit          m_valid;
  bit          m_redirect;
  int          m_taken;

  pc_update_unit_if #(.PC_WIDTH(32), .OFFSET_WIDTH(8)) bus ();

  pc_update_unit #(.PC_WIDTH(32), .OFFSET_WIDTH(8), .RESET_VECTOR(32'h0)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report a mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_booting  = 1'b1;
    m_valid    = 1'b0;
    m_redirect = 1'b0;
    m_taken    = 0;
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_edge(input bit fs, input logic [7:0] off, input bit bw);
    longint nxt;
    if (m_booting) begin
      m_booting  = 1'b0;
      m_valid    = 1'b1;
      m_redirect = 1'b0;
    end else if (bw) begin
      m_redirect = 1'b0;
    end else if (fs) begin
      nxt        = longint'(m_pc) + 4 + 4 * longint'($signed(off));
      m_pc       = 32'(nxt);
      m_redirect = 1'b1;
      if (m_taken < 65535) m_taken++;
    end else begin
      m_pc       = m_pc + 32'd4;
      m_redirect = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},       bus.PC,                  m_pc);
    check({tag, ".pc4"},      bus.PC_PLUS4,            m_pc + 32'd4);
    check({tag, ".valid"},    32'(bus.INSTR_VALID),    32'(m_valid));
    check({tag, ".redirect"}, 32'(bus.REDIRECT),       32'(m_redirect));
    check({tag, ".taken"},    32'(bus.TAKEN_COUNT),    32'(m_taken));
  endtask

  // Drive inputs, take one edge, then compare just after it.
  task automatic step(input bit fs, input logic [7:0] off, input bit bw, input bit do_chk);
    bus.FLOW_SELECT   = fs;
    bus.BRANCH_OFFSET = off;
    bus.BUSYWAIT      = bw;
    @(posedge clk);
    model_edge(fs, off, bw);
    #1;
    if (do_chk) compare_all("step");
  endtask

  // Asynchronous mid-cycle reset, checked immediately, released on a falling edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.pc",       bus.PC,                 32'h0);
    check("rst.valid",    32'(bus.INSTR_VALID),   32'h0);
    check("rst.redirect", 32'(bus.REDIRECT),      32'h0);
    check("rst.taken",    32'(bus.TAKEN_COUNT),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all("boot");
  endtask

  task automatic seq_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    bus.FLOW_SELECT   = 1'b0;
    bus.BRANCH_OFFSET = 8'h00;
    bus.BUSYWAIT      = 1'b0;
    @(negedge clk);
    async_reset();

    // Boot edge keeps PC, then sequential 4, 8, 12.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check("boot.pc0",    bus.PC, 32'h0);
    check("boot.valid",  32'(bus.INSTR_VALID), 32'h1);
    seq_steps(3);
    check("seq.pc12",    bus.PC, 32'hC);
    seq_steps(1);

    // Taken branch from 0x10 with offset +3.
    step(1'b1, 8'h03, 1'b0, 1'b1);
    check("br.pc20",     bus.PC, 32'h20);
    check("br.redirect", 32'(bus.REDIRECT), 32'h1);
    check("br.taken",    32'(bus.TAKEN_COUNT), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("br.pulse_end", 32'(bus.REDIRECT), 32'h0);

    // Negative offsets and wrap-around from 0x10.
    async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    seq_steps(4);
    step(1'b1, 8'hFB, 1'b0, 1'b1);
    check("neg.pc0",     bus.PC, 32'h0);
    seq_steps(4);
    step(1'b1, 8'hFA, 1'b0, 1'b1);
    check("neg.pcfffc",  bus.PC, 32'hFFFF_FFFC);
    check("neg.pc4wrap", bus.PC_PLUS4, 32'h0);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    check("b2b.redirect", 32'(bus.REDIRECT), 32'h1);
    seq_steps(1);
    check("wrap.pc0",    bus.PC, 32'h0);

    // Stall at 0x08 with toggling flow select.
    async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    seq_steps(2);
    step(1'b1, 8'h05, 1'b1, 1'b1);
    step(1'b0, 8'h05, 1'b1, 1'b1);
    step(1'b1, 8'h05, 1'b1, 1'b1);
    check("stall.pc8",   bus.PC, 32'h8);
    check("stall.redir", 32'(bus.REDIRECT), 32'h0);
    step(1'b0, 8'h05, 1'b0, 1'b1);
    check("stall.pcC",   bus.PC, 32'hC);
    check("stall.taken", 32'(bus.TAKEN_COUNT), 32'h0);

    // Reset mid-cycle while stalled at 0x40 with a nonzero count.
    step(1'b1, 8'h0C, 1'b0, 1'b1);
    check("pre.pc40",    bus.PC, 32'h40);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    async_reset();
    step(1'b1, 8'h10, 1'b0, 1'b1);
    check("reboot.pc0",  bus.PC, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1);
    end

    // Saturation of the taken counter.
    async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 65535; i++) step(1'b1, 8'hFF, 1'b0, 1'b0);
    compare_all("sat");
    check("sat.ffff",    32'(bus.TAKEN_COUNT), 32'hFFFF);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    check("sat.hold",    32'(bus.TAKEN_COUNT), 32'hFFFF);
    check("sat.pc",      bus.PC, 32'hC);
    check("sat.redir",   32'(bus.REDIRECT), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
